// File: rtl/set_ctrl.sv
// Two-way set controller: compares request tags against two ways, picks a victim on
// write misses and hands each access to the owning data block, waiting for its ack.
module set_ctrl #(
    parameter int TAG_W   = 8,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [0:15]      req_data,
    input  logic             req_flush,
    output logic             req_ready,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_err,
    output logic [0:15]      resp_data,
    output logic [1:0]       blk_enable,
    output logic             blk_write,
    output logic             blk_rst,
    output logic [0:15]      blk_data_in,
    input  logic [0:15]      blk_data_out0,
    input  logic [0:15]      blk_data_out1,
    input  logic [1:0]       blk_ack
);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_ACCESS, S_FLUSH, S_RESP} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_write;
    logic [TAG_W-1:0] r_tag;
    logic [0:15]      r_data;
    logic [1:0]       r_valid;
    logic [TAG_W-1:0] r_tags [2];
    logic             r_lru;
    logic             r_way;
    logic             r_hit;
    logic [7:0]       r_cnt;
    logic             r_respHit;
    logic             r_respErr;
    logic [0:15]      r_respData;

    logic             w_hit0;
    logic             w_hit1;
    logic             w_hitAny;
    logic             w_victim;
    logic             w_lookupWay;
    logic             w_selAck;
    logic             w_timeout;
    logic [0:15]      w_selData;

    assign w_hit0      = r_valid[0] && (r_tags[0] == r_tag);
    assign w_hit1      = r_valid[1] && (r_tags[1] == r_tag);
    assign w_hitAny    = w_hit0 || w_hit1;
    assign w_victim    = !r_valid[0] ? 1'b0 : (!r_valid[1] ? 1'b1 : r_lru);
    assign w_lookupWay = w_hitAny ? !w_hit0 : w_victim;
    assign w_selAck    = r_way ? blk_ack[1] : blk_ack[0];
    assign w_selData   = r_way ? blk_data_out1 : blk_data_out0;
    // An ack in the final allowed cycle still wins over the timeout.
    assign w_timeout   = !w_selAck && (r_cnt == LAST_WAIT);

    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        blk_enable  = 2'b00;
        blk_write   = 1'b0;
        blk_rst     = 1'b0;
        blk_data_in = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_flush) begin
                    w_next = S_FLUSH;
                end else if (req_valid) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_next = (!r_write && !w_hitAny) ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                blk_enable  = r_way ? 2'b10 : 2'b01;
                blk_write   = r_write;
                blk_data_in = r_data;
                if (w_selAck || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_FLUSH: begin
                blk_enable = 2'b11;
                blk_rst    = 1'b1;
                w_next     = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign resp_hit  = r_respHit;
    assign resp_err  = r_respErr;
    assign resp_data = r_respData;

    // Response registers default to zero and are only loaded on the edge into RESP,
    // so they read as zero in every other cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_tag      <= '0;
            r_data     <= '0;
            r_valid    <= 2'b00;
            r_tags[0]  <= '0;
            r_tags[1]  <= '0;
            r_lru      <= 1'b0;
            r_way      <= 1'b0;
            r_hit      <= 1'b0;
            r_cnt      <= '0;
            r_respHit  <= 1'b0;
            r_respErr  <= 1'b0;
            r_respData <= '0;
        end else begin
            r_state    <= w_next;
            r_respHit  <= 1'b0;
            r_respErr  <= 1'b0;
            r_respData <= '0;
            case (r_state)
                S_IDLE: begin
                    if (!req_flush && req_valid) begin
                        r_write <= req_write;
                        r_tag   <= req_tag;
                        r_data  <= req_data;
                    end
                end
                S_LOOKUP: begin
                    r_hit <= w_hitAny;
                    r_way <= w_lookupWay;
                    r_cnt <= '0;
                    if (r_write && !w_hitAny) begin
                        r_tags[w_victim] <= r_tag;
                    end
                end
                S_ACCESS: begin
                    if (w_selAck) begin
                        r_valid[r_way] <= 1'b1;
                        r_lru          <= ~r_way;
                        r_respHit      <= r_hit;
                        r_respData     <= r_write ? '0 : w_selData;
                    end else if (w_timeout) begin
                        r_valid[r_way] <= 1'b0;
                        r_respHit      <= r_hit;
                        r_respErr      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_FLUSH: begin
                    r_valid <= 2'b00;
                    r_lru   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_set_ctrl.sv
// Scoreboard bench for set_ctrl: a fake data block answers the handshake while a
// behavioural cache model predicts every response, block access and its timing.
module tb_set_ctrl;
    localparam int TAG_W   = 8;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_write = 1'b0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [0:15]      req_data = '0;
    logic             req_flush = 1'b0;
    logic             req_ready;
    logic             resp_valid;
    logic             resp_hit;
    logic             resp_err;
    logic [0:15]      resp_data;
    logic [1:0]       blk_enable;
    logic             blk_write;
    logic             blk_rst;
    logic [0:15]      blk_data_in;
    logic [0:15]      blk_data_out0;
    logic [0:15]      blk_data_out1;
    logic [1:0]       blk_ack;

    always #5 clk = ~clk;

    set_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_tag      (req_tag),
        .req_data     (req_data),
        .req_flush    (req_flush),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_err     (resp_err),
        .resp_data    (resp_data),
        .blk_enable   (blk_enable),
        .blk_write    (blk_write),
        .blk_rst      (blk_rst),
        .blk_data_in  (blk_data_in),
        .blk_data_out0(blk_data_out0),
        .blk_data_out1(blk_data_out1),
        .blk_ack      (blk_ack)
    );

    typedef struct {
        logic        hit;
        logic        err;
        logic [15:0] data;
        longint      cyc;
    } resp_t;

    typedef struct {
        logic [1:0]  en;
        logic        wr;
        logic [15:0] din;
        logic        rstb;
        int          len;
    } acc_t;

    resp_t respQ[$];
    acc_t  accQ[$];

    int     checks = 0;
    int     passes = 0;
    longint cycCnt = 0;

    bit          mValid [2];
    logic [7:0]  mTag [2];
    bit          mLru;
    logic [15:0] mData [2];

    int          ackDelay = 0;
    bit          ackStuck = 1'b0;
    logic [0:15] blkMem [2];

    assign blk_data_out0 = blkMem[0];
    assign blk_data_out1 = blkMem[1];

    always @(posedge clk) cycCnt <= cycCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cycCnt);
        end
    endtask

    task automatic failNote(input string name);
        checks++;
        $display("[TB] FAIL %s at cycle %0d", name, cycCnt);
    endtask

    task automatic modelClear();
        mValid[0] = 1'b0;
        mValid[1] = 1'b0;
        mLru      = 1'b0;
    endtask

    // Cache semantics at transaction level: hit lookup, victim choice, LRU and latency.
    task automatic modelReq(input bit wr, input logic [7:0] tag, input logic [15:0] data,
                            input bit flush, output resp_t r, output bit hasAcc, output acc_t a);
        int hitWay;
        int way;
        int lat;
        r.hit = 1'b0; r.err = 1'b0; r.data = '0;
        a.en = 2'b00; a.wr = 1'b0; a.din = '0; a.rstb = 1'b0; a.len = 0;
        hasAcc = 1'b0;
        lat = 2;
        if (flush) begin
            modelClear();
            hasAcc = 1'b1;
            a.en   = 2'b11;
            a.rstb = 1'b1;
            a.len  = 1;
        end else begin
            hitWay = -1;
            for (int w = 1; w >= 0; w--) begin
                if (mValid[w] && mTag[w] == tag) hitWay = w;
            end
            if (wr || hitWay >= 0) begin
                if (hitWay >= 0)     way = hitWay;
                else if (!mValid[0]) way = 0;
                else if (!mValid[1]) way = 1;
                else                 way = int'(mLru);
                if (hitWay < 0) mTag[way] = tag;
                hasAcc = 1'b1;
                a.en   = (way == 1) ? 2'b10 : 2'b01;
                a.wr   = wr;
                a.din  = data;
                r.hit  = (hitWay >= 0);
                if (ackStuck) begin
                    mValid[way] = 1'b0;
                    r.err = 1'b1;
                    a.len = TIMEOUT;
                    lat   = 2 + TIMEOUT;
                end else begin
                    mValid[way] = 1'b1;
                    mLru = (way == 0);
                    if (wr) mData[way] = data;
                    else    r.data = mData[way];
                    a.len = ackDelay + 1;
                    lat   = 3 + ackDelay;
                end
            end
        end
        r.cyc = cycCnt + lat;
    endtask

    task automatic applyStimulus(input bit wr, input logic [7:0] tag, input logic [15:0] data,
                                 input bit flush, input bit waitResp);
        resp_t r;
        acc_t  a;
        bit    hasAcc;
        int    n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) failNote("readyWait");
        req_valid = 1'b1;
        req_write = wr;
        req_tag   = tag;
        req_data  = data;
        req_flush = flush;
        modelReq(wr, tag, data, flush, r, hasAcc, a);
        respQ.push_back(r);
        if (hasAcc) accQ.push_back(a);
        @(negedge clk);
        req_valid = 1'b0;
        req_flush = 1'b0;
        if (waitResp) begin
            n = 0;
            while (respQ.size() != 0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (respQ.size() != 0) begin
                failNote("respWait");
                respQ.delete();
                accQ.delete();
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        modelClear();
        respQ.delete();
        accQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Fake data block: ack after ackDelay enabled cycles, store writes, clear on blk_rst.
    initial begin
        int waitCnt;
        waitCnt   = 0;
        blk_ack   = 2'b00;
        blkMem[0] = '0;
        blkMem[1] = '0;
        forever begin
            @(negedge clk);
            if (blk_enable == 2'b11) begin
                if (blk_rst) begin
                    blkMem[0] = '0;
                    blkMem[1] = '0;
                end
                blk_ack = 2'b00;
                waitCnt = 0;
            end else if (blk_enable != 2'b00) begin
                if (!ackStuck && waitCnt >= ackDelay) begin
                    blk_ack = blk_enable;
                    if (blk_write) blkMem[blk_enable[1]] = blk_data_in;
                end else begin
                    blk_ack = 2'b00;
                end
                waitCnt++;
            end else begin
                blk_ack = 2'b00;
                waitCnt = 0;
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (resp_valid) begin
                    if (respQ.size() == 0) begin
                        failNote("unexpectedResp");
                    end else begin
                        e = respQ.pop_front();
                        checkOutput("respHit", resp_hit, e.hit);
                        checkOutput("respErr", resp_err, e.err);
                        checkOutput("respData", resp_data, e.data);
                        checkOutput("respCycle", cycCnt[31:0], e.cyc[31:0]);
                        checkOutput("respStrobes", {blk_enable, blk_write, req_ready}, 4'b0000);
                    end
                end else begin
                    checkOutput("quietResp", {resp_hit, resp_err, resp_data}, 18'h0);
                end
            end
        end
    end

    // Block-access monitor: pattern, strobes and length of each enable burst.
    initial begin
        acc_t cur;
        int   runLen;
        bit   haveCur;
        runLen  = 0;
        haveCur = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                runLen  = 0;
                haveCur = 1'b0;
            end else if (blk_enable != 2'b00) begin
                if (runLen == 0) begin
                    if (accQ.size() == 0) begin
                        failNote("unexpectedEnable");
                    end else begin
                        cur = accQ.pop_front();
                        haveCur = 1'b1;
                        checkOutput("blkEnable", blk_enable, cur.en);
                        checkOutput("blkRst", blk_rst, cur.rstb);
                        if (!cur.rstb) begin
                            checkOutput("blkWrite", blk_write, cur.wr);
                            checkOutput("blkDataIn", blk_data_in, cur.din);
                        end
                    end
                end
                runLen++;
            end else if (runLen > 0) begin
                if (haveCur) checkOutput("enableCycles", runLen, cur.len);
                runLen  = 0;
                haveCur = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] tagPool [4];
        logic [7:0] t;
        bit         w;
        bit         f;
        tagPool[0] = 8'h05;
        tagPool[1] = 8'h09;
        tagPool[2] = 8'h0C;
        tagPool[3] = 8'h33;
        modelClear();

        #3 rst = 1'b0;
        #1;
        checkOutput("resetReady", req_ready, 1'b1);
        checkOutput("resetOutputs", {resp_valid, resp_hit, resp_err, blk_enable, blk_write, blk_rst}, 7'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] read miss, write, read hit");
        applyStimulus(1'b0, 8'h05, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h05, 16'h0F0F, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h05, 16'h0000, 1'b0, 1'b1);

        $display("[TB] LRU victim selection");
        doReset();
        applyStimulus(1'b1, 8'h05, 16'h1111, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h09, 16'h2222, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h05, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h0C, 16'h3333, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h09, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h05, 16'h0000, 1'b0, 1'b1);

        $display("[TB] ack timeout");
        doReset();
        ackStuck = 1'b1;
        applyStimulus(1'b1, 8'h33, 16'hA5A5, 1'b0, 1'b1);
        ackStuck = 1'b0;
        applyStimulus(1'b0, 8'h33, 16'h0000, 1'b0, 1'b1);

        $display("[TB] flush beats simultaneous request");
        applyStimulus(1'b1, 8'h0A, 16'h0A0A, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h0B, 16'h0B0B, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h0A, 16'h0000, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h0A, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h0B, 16'h0000, 1'b0, 1'b1);

        $display("[TB] asynchronous reset during access stall");
        applyStimulus(1'b1, 8'h44, 16'hBEEF, 1'b0, 1'b1);
        ackStuck = 1'b1;
        applyStimulus(1'b1, 8'h44, 16'hCAFE, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("stallEnable", blk_enable, 2'b01);
        #2 rst = 1'b0;
        #1;
        checkOutput("asyncEnable", blk_enable, 2'b00);
        checkOutput("asyncReady", req_ready, 1'b1);
        checkOutput("asyncOthers", {resp_valid, blk_write, blk_rst}, 3'b000);
        modelClear();
        respQ.delete();
        accQ.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ackStuck = 1'b0;
        applyStimulus(1'b0, 8'h44, 16'h0000, 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 200; i++) begin
            t = tagPool[$urandom_range(0, 3)];
            w = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 15) == 0);
            ackDelay = $urandom_range(0, 3);
            applyStimulus(w, t, 16'($urandom), f, 1'b1);
        end
        ackDelay = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
